// File: rtl/ibex_icache_ram_pkg.sv
// Shared types and constants for the icache tag-RAM scrub wrapper and its key register.
// Pure definitions: no latency, no flow control.
package ibex_icache_ram_pkg;

  typedef enum logic {
    SCRUB = 1'b0,
    IDLE  = 1'b1
  } scrub_state_e;

  localparam int unsigned DefaultTagWidth = 22;
  localparam logic [DefaultTagWidth-1:0] DefaultInvalidTag = '0;

  function automatic int unsigned IdxW(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

endpackage

// File: rtl/ibex_icache_key_reg.sv
// Scramble key/nonce/valid registers; loads one cycle after key_valid_i, valid sticks until reset.
// No backpressure: every key_valid_i pulse is captured.
module ibex_icache_key_reg #(
  parameter int unsigned KeyWidth   = 128,
  parameter int unsigned NonceWidth = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  key_valid_i,
  input  logic [KeyWidth-1:0]   key_i,
  input  logic [NonceWidth-1:0] nonce_i,
  output logic                  key_valid_q_o,
  output logic [KeyWidth-1:0]   key_q_o,
  output logic [NonceWidth-1:0] nonce_q_o
);

  logic                  key_valid_q;
  logic [KeyWidth-1:0]   key_q;
  logic [NonceWidth-1:0] nonce_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_valid_q <= 1'b0;
      key_q       <= '0;
      nonce_q     <= '0;
    end else if (key_valid_i) begin
      key_valid_q <= 1'b1;
      key_q       <= key_i;
      nonce_q     <= nonce_i;
    end
  end

  assign key_valid_q_o = key_valid_q;
  assign key_q_o       = key_q;
  assign nonce_q_o     = nonce_q;

endmodule

// File: rtl/ibex_icache_ram_scrub.sv
// Tag-bank front end: zero-latency core pass-through when idle, NumLines-cycle invalidate walk otherwise.
// Core is stalled (tag_gnt_o=0) while scrubbing; optional IBEX_ICACHE_SCRUB_CNT_EN adds a pass counter.
module ibex_icache_ram_scrub
  import ibex_icache_ram_pkg::*;
#(
  parameter int unsigned          NumWays    = 2,
  parameter int unsigned          NumLines   = 64,
  parameter int unsigned          TagWidth   = DefaultTagWidth,
  parameter int unsigned          KeyWidth   = 128,
  parameter int unsigned          NonceWidth = 64,
  parameter logic [TagWidth-1:0]  InvalidTag = TagWidth'(DefaultInvalidTag)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        key_valid_i,
  input  logic [KeyWidth-1:0]         key_i,
  input  logic [NonceWidth-1:0]       nonce_i,
  input  logic                        inval_req_i,
  input  logic [NumWays-1:0]          tag_req_i,
  input  logic                        tag_write_i,
  input  logic [$clog2(NumLines)-1:0] tag_addr_i,
  input  logic [TagWidth-1:0]         tag_wdata_i,
  output logic                        tag_gnt_o,
  output logic [NumWays-1:0]          ram_req_o,
  output logic                        ram_write_o,
  output logic [$clog2(NumLines)-1:0] ram_addr_o,
  output logic [TagWidth-1:0]         ram_wdata_o,
  output logic                        key_valid_q_o,
  output logic [KeyWidth-1:0]         key_q_o,
  output logic [NonceWidth-1:0]       nonce_q_o,
`ifdef IBEX_ICACHE_SCRUB_CNT_EN
  output logic [7:0]                  scrub_cnt_o,
`endif
  output logic                        busy_o
);

  localparam int unsigned           IdxWidth = IdxW(NumLines);
  localparam logic [IdxWidth-1:0]   LastIdx  = IdxWidth'(NumLines - 1);

  scrub_state_e          state_q, state_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic                  trigger;

  // A key change and an invalidate in the same cycle collapse into one restart.
  assign trigger = key_valid_i | inval_req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SCRUB;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tag_gnt_o   = 1'b0;
    ram_req_o   = '1;
    ram_write_o = 1'b1;
    ram_addr_o  = idx_q;
    ram_wdata_o = InvalidTag;

    unique case (state_q)
      SCRUB: begin
        if (trigger) begin
          idx_d = '0;
        end else if (idx_q == LastIdx) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      IDLE: begin
        tag_gnt_o   = |tag_req_i;
        ram_req_o   = tag_req_i;
        ram_write_o = tag_write_i;
        ram_addr_o  = tag_addr_i;
        ram_wdata_o = tag_wdata_i;
        if (trigger) begin
          state_d = SCRUB;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = SCRUB;
        idx_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == SCRUB);

  ibex_icache_key_reg #(
    .KeyWidth   (KeyWidth),
    .NonceWidth (NonceWidth)
  ) u_key_reg (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .key_valid_i   (key_valid_i),
    .key_i         (key_i),
    .nonce_i       (nonce_i),
    .key_valid_q_o (key_valid_q_o),
    .key_q_o       (key_q_o),
    .nonce_q_o     (nonce_q_o)
  );

`ifdef IBEX_ICACHE_SCRUB_CNT_EN
  logic [7:0] scrub_cnt_q;
  logic       pass_done;

  // Only a pass that reaches its last line untouched by a new trigger counts.
  assign pass_done = (state_q == SCRUB) && !trigger && (idx_q == LastIdx);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scrub_cnt_q <= '0;
    end else if (pass_done && (scrub_cnt_q != 8'hFF)) begin
      scrub_cnt_q <= scrub_cnt_q + 8'd1;
    end
  end

  assign scrub_cnt_o = scrub_cnt_q;
`endif

endmodule
